mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have parameter S, default 32, data and address width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port mem_valid, input, 1 bit: an instruction is present from the EX/MEM register.
REQ-005 The block SHALL have port mem_ALUout, input, S bits: ALU result, used as the byte address for loads and stores.
REQ-006 The block SHALL have port mem_zero, input, 2 bits: zero/branch flags, passed through to writeback.
REQ-007 The block SHALL have ports mem_read and mem_write, input, 1 bit each: load and store requests.
REQ-008 The block SHALL have ports mem_wdata (input, S bits, store data), mem_rd (input, 5 bits, destination register) and mem_regwrite (input, 1 bit, register write enable).
REQ-009 The block SHALL have port stall, output, 1 bit: upstream holds its inputs while this is high.
REQ-010 The block SHALL have ports dmem_req, dmem_we (output, 1 bit each), dmem_addr and dmem_wdata (output, S bits each), dmem_ack (input, 1 bit) and dmem_rdata (input, S bits).
REQ-011 The block SHALL have ports wb_valid, wb_regwrite (output, 1 bit each), wb_data (output, S bits), wb_rd (output, 5 bits) and wb_zero (output, 2 bits).

Function
REQ-012 The FSM SHALL have two states: IDLE and WAIT.
REQ-013 In IDLE, for a non-memory op (mem_valid=1, mem_read=0, mem_write=0), the next edge SHALL load wb_data=mem_ALUout, wb_rd, wb_regwrite and wb_zero, and SHALL set wb_valid=1.
- Latency 1 cycle; stall stays 0.
REQ-014 In IDLE, for a memory op (mem_valid=1 and mem_read|mem_write), the next edge SHALL do all of the following:
- latch dmem_addr=mem_ALUout and dmem_wdata=mem_wdata
- set dmem_we=mem_write&~mem_read and dmem_req=1
- enter WAIT
REQ-015 If mem_read and mem_write are both 1, the block SHALL perform a load only (read wins).
REQ-016 In WAIT, dmem_req, dmem_we, dmem_addr and dmem_wdata SHALL hold stable until dmem_ack=1 is sampled.
REQ-017 On the edge where dmem_ack=1 is sampled in WAIT, the block SHALL do all of the following:
- clear dmem_req
- return to IDLE
- set wb_valid=1
- for a load: wb_data=dmem_rdata, wb_regwrite=mem_regwrite
- for a store: wb_data unchanged, wb_regwrite=0
REQ-018 stall SHALL be combinational: 1 when (IDLE & mem_valid & (mem_read|mem_write)) or (WAIT & ~dmem_ack), otherwise 0.
REQ-019 wb_valid SHALL be a one-cycle pulse per retired instruction and SHALL be 0 in any cycle where nothing retires, including while mem_valid=0 in IDLE.
REQ-020 dmem_ack SHALL be ignored in IDLE.
REQ-021 The minimum memory-op latency SHALL be 2 cycles: the capture edge plus the ack edge.
REQ-022 Back-to-back memory ops SHALL be accepted in the IDLE cycle that immediately follows an ack.
REQ-023 The block SHALL not perform any address arithmetic; dmem_addr SHALL equal mem_ALUout bit-for-bit.

Reset
REQ-024 Asserting reset SHALL immediately force all of the following, independent of clk:
- state IDLE
- dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0
- wb_valid=0, wb_regwrite=0, wb_data=0, wb_rd=0, wb_zero=0
REQ-025 Reset during WAIT SHALL abort the access; a late dmem_ack after reset release SHALL be ignored.
REQ-026 The first instruction SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-027 With macro MEM_STAGE_MISALIGN_TRAP_EN defined, the block SHALL add output misalign (1 bit, reset 0).
REQ-028 With MEM_STAGE_MISALIGN_TRAP_EN defined, a memory op in IDLE with mem_ALUout[1:0]!=0 SHALL behave as follows:
- no access is issued (dmem_req stays 0)
- the next edge sets wb_valid=1, wb_regwrite=0 and misalign=1 for one cycle
- stall stays 0
REQ-029 Without MEM_STAGE_MISALIGN_TRAP_EN, the misalign port SHALL NOT exist, and every address SHALL be issued unchanged.

Verification
REQ-030 ALU op: mem_valid=1, mem_ALUout=0x0000_00A5, mem_rd=3, mem_regwrite=1 -> next cycle wb_valid=1, wb_data=0xA5, wb_rd=3, stall=0.
REQ-031 Load with 3-cycle ack delay: addr 0x100, dmem_rdata=0xDEAD_BEEF -> dmem_req high 3 cycles, stall high 3 cycles, then wb_data=0xDEADBEEF and wb_valid pulses once.
REQ-032 Store with immediate ack: addr 0x20, wdata 0x1234 -> dmem_we=1, dmem_wdata=0x1234 for 1 cycle, then wb_valid=1, wb_regwrite=0.
REQ-033 Reset asserted in WAIT, then dmem_ack=1 after release -> all outputs 0 at once, no wb_valid, state IDLE.
REQ-034 Read+write together at addr 0x40 -> dmem_we=0, the load completes normally.
REQ-035 With MEM_STAGE_MISALIGN_TRAP_EN defined, a load at 0x102 -> dmem_req stays 0, misalign=1, wb_regwrite=0.

Source files
------------

// File: rtl/mem_stage.sv
// Pipeline MEM stage: forwards ALU results and runs one data-memory access per load/store with a req/ack handshake.
// Optional misaligned-access trap enabled by defining MEM_STAGE_MISALIGN_TRAP_EN.
module mem_stage #(
  parameter int unsigned S = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_valid,
  input  logic [S-1:0] mem_ALUout,
  input  logic [1:0]   mem_zero,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [S-1:0] mem_wdata,
  input  logic [4:0]   mem_rd,
  input  logic         mem_regwrite,
  output logic         stall,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [S-1:0] dmem_addr,
  output logic [S-1:0] dmem_wdata,
  input  logic         dmem_ack,
  input  logic [S-1:0] dmem_rdata,
  output logic         wb_valid,
  output logic         wb_regwrite,
  output logic [S-1:0] wb_data,
  output logic [4:0]   wb_rd,
  output logic [1:0]   wb_zero
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  ,
  output logic         misalign
`endif
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t state;
  logic   mem_op_c;
  logic   bad_align_c;

  assign mem_op_c = mem_valid & (mem_read | mem_write);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign bad_align_c = mem_op_c & (mem_ALUout[1:0] != 2'b00);
`else
  assign bad_align_c = 1'b0;
`endif

  // Upstream holds while an access is being captured or is still outstanding
  assign stall = ((state == IDLE) & mem_op_c & ~bad_align_c) |
                 ((state == WAIT) & ~dmem_ack);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_data     <= '0;
      wb_rd       <= 5'd0;
      wb_zero     <= 2'd0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      misalign    <= 1'b0;
`endif
    end else begin
      wb_valid <= 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      misalign <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (mem_valid) begin
            if (bad_align_c) begin
              // Trap retires immediately with no register write and no access
              wb_valid    <= 1'b1;
              wb_regwrite <= 1'b0;
              wb_rd       <= mem_rd;
              wb_zero     <= mem_zero;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
              misalign    <= 1'b1;
`endif
            end else if (mem_read | mem_write) begin
              dmem_req   <= 1'b1;
              dmem_we    <= mem_write & ~mem_read;
              dmem_addr  <= mem_ALUout;
              dmem_wdata <= mem_wdata;
              state      <= WAIT;
            end else begin
              wb_valid    <= 1'b1;
              wb_data     <= mem_ALUout;
              wb_rd       <= mem_rd;
              wb_regwrite <= mem_regwrite;
              wb_zero     <= mem_zero;
            end
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            state    <= IDLE;
            wb_valid <= 1'b1;
            wb_rd    <= mem_rd;
            wb_zero  <= mem_zero;
            // dmem_we still reflects the captured op: low means load
            if (!dmem_we) begin
              wb_data     <= dmem_rdata;
              wb_regwrite <= mem_regwrite;
            end else begin
              wb_regwrite <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
